// File: rtl/colour_theme_sequencer.sv
// rtl/colour_theme_sequencer.sv - OLED colour theme selector with frame-aligned cross-fade
//
// Selects one of three five-colour palettes from the sw3/sw4 switches, waits for the
// selection to hold across STABLE_FRAMES frame starts, then walks the palette outputs
// from the committed theme to the new one over 2^STEP_BITS frames (or in one frame when
// fade_en is low). All state changes happen on frame_begin so a frame never tears.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   frame_begin  one-cycle pulse at the start of each OLED frame
//   sw3, sw4     asynchronous theme-select switches
//   fade_en      1 = cross-fade across frames, 0 = switch in a single frame
//   bor_col      RGB565 border colour
//   bg_col       RGB565 background colour
//   volCol_top   RGB565 volume-bar top colour
//   volCol_mid   RGB565 volume-bar middle colour
//   volCol_bot   RGB565 volume-bar bottom colour
//   busy         high while a transition is in progress
//   theme        committed theme index

module colour_theme_sequencer #(
  parameter int STEP_BITS     = 3,
  parameter int STABLE_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        sw3,
  input  logic        sw4,
  input  logic        fade_en,
  output logic [15:0] bor_col,
  output logic [15:0] bg_col,
  output logic [15:0] volCol_top,
  output logic [15:0] volCol_mid,
  output logic [15:0] volCol_bot,
  output logic        busy,
  output logic [1:0]  theme
);

  typedef struct packed {
    logic [15:0] bor;
    logic [15:0] bg;
    logic [15:0] top;
    logic [15:0] mid;
    logic [15:0] bot;
  } palette_t;

  typedef enum logic {IDLE, FADE} state_t;

  localparam int SCW = $clog2(STABLE_FRAMES + 1);
  localparam logic [SCW-1:0]     STABLE_N  = SCW'(STABLE_FRAMES);
  localparam logic [STEP_BITS:0] STEP_FULL = {1'b1, {STEP_BITS{1'b0}}};
  localparam logic [1:0]         REQ_NONE  = 2'd3;

  localparam palette_t PAL_T0 = {16'hFFFF, 16'h0000, 16'hF800, 16'hFFE0, 16'h07E0};
  localparam palette_t PAL_T1 = {16'h001F, 16'h0000, 16'hF800, 16'h07E0, 16'hFFFF};
  localparam palette_t PAL_T2 = {16'h0000, 16'hFFFF, 16'hF81F, 16'hFFE0, 16'h07FF};

  function automatic palette_t theme_palette(input logic [1:0] t);
    case (t)
      2'd1:    return PAL_T1;
      2'd2:    return PAL_T2;
      default: return PAL_T0;
    endcase
  endfunction

  // One colour field (width w at bit lo) of src + ((dst - src) * k) >>> STEP_BITS.
  // The arithmetic shift floors, so the result never leaves [min, max] of the two
  // endpoints and cannot overflow the field; masking only drops the zero upper bits.
  function automatic logic [15:0] lerp_field(input logic [15:0] s, input logic [15:0] d,
                                             input logic [STEP_BITS:0] k,
                                             input int lo, input int w);
    int m;
    int sx;
    int dx;
    int prod;
    m    = (1 << w) - 1;
    sx   = int'(s >> lo) & m;
    dx   = int'(d >> lo) & m;
    prod = (dx - sx) * int'(k);
    return 16'(((sx + (prod >>> STEP_BITS)) & m) << lo);
  endfunction

  function automatic logic [15:0] lerp565(input logic [15:0] s, input logic [15:0] d,
                                          input logic [STEP_BITS:0] k);
    return lerp_field(s, d, k, 11, 5) | lerp_field(s, d, k, 5, 6) | lerp_field(s, d, k, 0, 5);
  endfunction

  function automatic palette_t mix_palette(input palette_t s, input palette_t d,
                                           input logic [STEP_BITS:0] k);
    palette_t r;
    r.bor = lerp565(s.bor, d.bor, k);
    r.bg  = lerp565(s.bg,  d.bg,  k);
    r.top = lerp565(s.top, d.top, k);
    r.mid = lerp565(s.mid, d.mid, k);
    r.bot = lerp565(s.bot, d.bot, k);
    return r;
  endfunction

  // Switch synchronisers
  logic sw3_meta, sw3_sync, sw4_meta, sw4_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw3_meta <= 1'b0;
      sw3_sync <= 1'b0;
      sw4_meta <= 1'b0;
      sw4_sync <= 1'b0;
    end else begin
      sw3_meta <= sw3;
      sw3_sync <= sw3_meta;
      sw4_meta <= sw4;
      sw4_sync <= sw4_meta;
    end
  end

  // Request decode: code 3 means "no request", and is tracked for stability like any
  // other code so that leaving it also has to settle before acting.
  logic [1:0] req_now;

  always_comb begin
    req_now = REQ_NONE;
    case ({sw3_sync, sw4_sync})
      2'b00:   req_now = 2'd0;
      2'b10:   req_now = 2'd1;
      2'b11:   req_now = 2'd2;
      default: req_now = REQ_NONE;
    endcase
  end

  // Stability tracking, advanced once per frame; the counter saturates at STABLE_N.
  logic [1:0]     req_last;
  logic [SCW-1:0] stab_cnt;
  logic [SCW-1:0] stab_cnt_d;
  logic           req_stable;

  assign stab_cnt_d = (req_now != req_last) ? SCW'(1) :
                      (stab_cnt == STABLE_N) ? stab_cnt : stab_cnt + 1'b1;

  // Evaluated with this frame's updated count so the fade starts on the same frame_begin.
  assign req_stable = frame_begin && (stab_cnt_d == STABLE_N) && (req_now != REQ_NONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_last <= 2'd0;
      stab_cnt <= '0;
    end else if (frame_begin) begin
      req_last <= req_now;
      stab_cnt <= stab_cnt_d;
    end
  end

  // Transition FSM
  state_t               state_q, state_d;
  logic [1:0]           src_q, src_d;
  logic [1:0]           dst_q, dst_d;
  logic [1:0]           theme_q, theme_d;
  logic [STEP_BITS:0]   step_q, step_d;
  logic [STEP_BITS:0]   step_inc;
  logic                 busy_q, busy_d;
  palette_t             pal_q, pal_d;

  assign step_inc = fade_en ? step_q + 1'b1 : STEP_FULL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= 2'd0;
      dst_q   <= 2'd0;
      theme_q <= 2'd0;
      step_q  <= '0;
      busy_q  <= 1'b0;
      pal_q   <= PAL_T0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      theme_q <= theme_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      pal_q   <= pal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    theme_d = theme_q;
    step_d  = step_q;
    busy_d  = busy_q;
    pal_d   = pal_q;
    case (state_q)
      IDLE: begin
        // Entering at step 0 leaves the outputs on the source palette for this frame.
        if (req_stable && (req_now != theme_q)) begin
          src_d   = theme_q;
          dst_d   = req_now;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = FADE;
        end
      end
      FADE: begin
        // Requests are still tracked above but not acted on until back in IDLE.
        if (frame_begin) begin
          step_d = step_inc;
          if (step_inc == STEP_FULL) begin
            pal_d   = theme_palette(dst_q);
            theme_d = dst_q;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pal_d = mix_palette(theme_palette(src_q), theme_palette(dst_q), step_inc);
          end
        end
      end
    endcase
  end

  assign bor_col    = pal_q.bor;
  assign bg_col     = pal_q.bg;
  assign volCol_top = pal_q.top;
  assign volCol_mid = pal_q.mid;
  assign volCol_bot = pal_q.bot;
  assign busy       = busy_q;
  assign theme      = theme_q;

endmodule
